gost_block_packer: RTL and testbench
====================================

GOST_BLOCK_PACKER -- requirements
Module: gost_block_packer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1: 1 = first byte of a block lands in m_axis_tdata[63:56]; 0 = first byte lands in [7:0].
REQ-002 SHALL have parameter PAD_BYTE, default 8'h00: fill value for unused byte lanes when GOST_PAD_EN is undefined.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock, sole clock domain.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 s_axis_tdata  in  8  input byte.
REQ-007 s_axis_tvalid  in  1  input byte valid.
REQ-008 s_axis_tready  out  1  packer accepts a byte this cycle.
REQ-009 s_axis_tlast  in  1  byte is the last of a message.
REQ-010 m_axis_tdata  out  64  packed block to cipher pipeline.
REQ-011 m_axis_tvalid  out  1  block valid.
REQ-012 m_axis_tready  in  1  downstream accepts block.
REQ-013 m_axis_tkeep  out  8  valid-byte mask for the block.
REQ-014 m_axis_tlast  out  1  block is the last of a message.
REQ-015 blk_cnt  out  32  count of blocks handed off (m handshakes), wraps at 2^32.

Function
REQ-016 Byte handshake = s_axis_tvalid & s_axis_tready; block handshake = m_axis_tvalid & m_axis_tready.
REQ-017 Accumulator with 3-bit byte index cnt; byte k (0..7) written to lane [63-8k -: 8] if MSB_FIRST else [8k+7 -: 8].
REQ-018 Block completes on a byte handshake with cnt==7 or s_axis_tlast==1.
REQ-019 State machine: FILL (collecting), WAIT (completed block, output register occupied), PAD (pad-only block pending, GOST_PAD_EN only).
REQ-020 s_axis_tready SHALL be 1 only in FILL; 0 in WAIT and PAD.
REQ-021 Output register is free when m_axis_tvalid==0 or a block handshake occurs in the same cycle.
REQ-022 On completion in FILL with output register free: block loads into the output register at that edge (m_axis_tvalid high next cycle, latency 1), cnt returns to 0, state stays FILL.
REQ-023 On completion with output register not free: block held, state -> WAIT; WAIT -> FILL at the edge where the output register becomes free, loading the block.
REQ-024 m_axis_tdata/tkeep/tlast SHALL remain stable while m_axis_tvalid==1 and m_axis_tready==0.
REQ-025 m_axis_tkeep: one bit per lane filled by an input byte, same lane ordering as data; full block = 8'hFF.
REQ-026 m_axis_tlast = s_axis_tlast of the completing byte, except as modified by REQ-033.
REQ-027 blk_cnt increments by 1 per block handshake, 32-bit wrap 32'hFFFFFFFF -> 0.
REQ-028 s_axis_tlast on byte index 7 produces a full block with tlast=1; no empty block is ever emitted (absent GOST_PAD_EN).
REQ-029 Simultaneous completion and block handshake in the same cycle SHALL not stall (REQ-021).

Reset
REQ-030 While rst_n==0 at a rising edge: state=FILL, cnt=0, accumulator discarded, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, blk_cnt=0; s_axis_tready=0 during reset.
REQ-031 Reset mid-block or in WAIT/PAD SHALL discard partial and pending blocks; no block emitted from pre-reset data.

Configuration
REQ-032 Macro GOST_PAD_EN selects ISO/IEC 7816-4 padding.
REQ-033 Defined: final partial block padded with 8'h80 at first unused lane then 8'h00, tkeep=8'hFF, tlast=1; if the message ends on a full block, that block has tlast=0 and state enters PAD, emitting 64'h8000_0000_0000_0000 (lane order per MSB_FIRST) with tkeep=8'hFF, tlast=1, then returning to FILL.
REQ-034 Undefined: unused lanes = PAD_BYTE, tkeep marks real bytes, PAD state unreachable.

Verification
REQ-035 MSB_FIRST=1, bytes 01..08 back-to-back, m_axis_tready=1 -> m_axis_tdata=64'h0102030405060708, tkeep=FF, tlast=0, m_axis_tvalid one cycle after byte 08.
REQ-036 No pad: 3 bytes AA,BB,CC with tlast on CC -> tdata=64'hAABBCC0000000000, tkeep=8'hE0, tlast=1.
REQ-037 GOST_PAD_EN: same 3 bytes -> tdata=64'hAABBCC8000000000, tkeep=FF, tlast=1; 8 bytes with tlast -> data block tlast=0 then 64'h8000000000000000 tlast=1.
REQ-038 m_axis_tready=0 for 20 cycles during 16 input bytes -> s_axis_tready drops after second block completes (WAIT), output stable, both blocks delivered in order after release, blk_cnt=2.
REQ-039 rst_n=0 after 5 bytes of a block -> no output; next 8 bytes 11..18 give 64'h1112131415161718.
REQ-040 blk_cnt forced near wrap (via 2^32 blocks or backdoor 32'hFFFFFFFF) -> next handshake yields 0.

Source files
------------

// File: rtl/gost_block_packer.sv
//==============================================================================
// Module   : gost_block_packer
// Purpose  : Packs an 8-bit AXI-Stream into 64-bit blocks for a GOST cipher
//            pipeline. Define GOST_PAD_EN for ISO/IEC 7816-4 padding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gost_block_packer #(
    parameter int         MSB_FIRST = 1,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic [31:0] blk_cnt
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_WAIT = 2'd1,
        S_PAD  = 2'd2
    } state_t;

`ifdef GOST_PAD_EN
    localparam logic [63:0] c_acc_init = 64'h0;
    localparam logic [63:0] c_pad_blk  = (MSB_FIRST != 0) ? {8'h80, 56'h0} : {56'h0, 8'h80};
`else
    localparam logic [63:0] c_acc_init = {8{PAD_BYTE}};
`endif

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [63:0] r_acc;
    logic [7:0]  r_keep;
    logic        r_hold_last;
    logic        r_hold_pad;
    logic [63:0] r_m_data;
    logic [7:0]  r_m_keep;
    logic        r_m_last;
    logic        r_m_valid;
    logic [31:0] r_blk_cnt;

    logic        w_s_hs;
    logic        w_m_hs;
    logic        w_done;
    logic        w_out_free;
    logic [2:0]  w_lane;
    logic [2:0]  w_next_lane;
    logic [63:0] w_blk_data;
    logic [7:0]  w_blk_keep;
    logic        w_blk_last;
    logic        w_need_pad;

    // Physical byte position of logical byte index k within the block.
    function automatic logic [2:0] lane_of(input logic [2:0] k);
        lane_of = (MSB_FIRST != 0) ? ~k : k;
    endfunction

    assign s_axis_tready = rst_n && (r_state == S_FILL);
    assign w_s_hs        = s_axis_tvalid && s_axis_tready;
    assign w_m_hs        = r_m_valid && m_axis_tready;
    assign w_done        = w_s_hs && ((r_cnt == 3'd7) || s_axis_tlast);
    assign w_out_free    = !r_m_valid || m_axis_tready;
    assign w_lane        = lane_of(r_cnt);
    assign w_next_lane   = lane_of(r_cnt + 3'd1);

    // Block as it would look if the current input byte completes it.
    always_comb begin
        w_blk_data = r_acc;
        w_blk_keep = r_keep;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) == w_lane) begin
                w_blk_data[8*i +: 8] = s_axis_tdata;
                w_blk_keep[i]        = 1'b1;
            end
        end
`ifdef GOST_PAD_EN
        w_blk_last = s_axis_tlast && (r_cnt != 3'd7);
        w_need_pad = s_axis_tlast && (r_cnt == 3'd7);
        if (w_blk_last) begin
            for (int i = 0; i < 8; i++) begin
                if (3'(i) == w_next_lane) begin
                    w_blk_data[8*i +: 8] = 8'h80;
                end
            end
            w_blk_keep = 8'hFF;
        end
`else
        w_blk_last = s_axis_tlast;
        w_need_pad = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_cnt       <= 3'd0;
            r_acc       <= c_acc_init;
            r_keep      <= 8'h00;
            r_hold_last <= 1'b0;
            r_hold_pad  <= 1'b0;
            r_m_data    <= 64'h0;
            r_m_keep    <= 8'h00;
            r_m_last    <= 1'b0;
            r_m_valid   <= 1'b0;
            r_blk_cnt   <= 32'h0;
        end else begin
            if (w_m_hs) begin
                r_m_valid <= 1'b0;
                r_blk_cnt <= r_blk_cnt + 32'd1;
            end
            case (r_state)
                S_FILL: begin
                    if (w_done) begin
                        r_cnt <= 3'd0;
                        if (w_out_free) begin
                            r_m_data  <= w_blk_data;
                            r_m_keep  <= w_blk_keep;
                            r_m_last  <= w_blk_last;
                            r_m_valid <= 1'b1;
                            r_acc     <= c_acc_init;
                            r_keep    <= 8'h00;
                            r_state   <= w_need_pad ? S_PAD : S_FILL;
                        end else begin
                            r_acc       <= w_blk_data;
                            r_keep      <= w_blk_keep;
                            r_hold_last <= w_blk_last;
                            r_hold_pad  <= w_need_pad;
                            r_state     <= S_WAIT;
                        end
                    end else if (w_s_hs) begin
                        r_acc  <= w_blk_data;
                        r_keep <= w_blk_keep;
                        r_cnt  <= r_cnt + 3'd1;
                    end
                end
                S_WAIT: begin
                    if (w_out_free) begin
                        r_m_data  <= r_acc;
                        r_m_keep  <= r_keep;
                        r_m_last  <= r_hold_last;
                        r_m_valid <= 1'b1;
                        r_acc     <= c_acc_init;
                        r_keep    <= 8'h00;
                        r_state   <= r_hold_pad ? S_PAD : S_FILL;
                    end
                end
                S_PAD: begin
`ifdef GOST_PAD_EN
                    if (w_out_free) begin
                        r_m_data  <= c_pad_blk;
                        r_m_keep  <= 8'hFF;
                        r_m_last  <= 1'b1;
                        r_m_valid <= 1'b1;
                        r_state   <= S_FILL;
                    end
`else
                    r_state <= S_FILL;
`endif
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign m_axis_tdata  = r_m_data;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tvalid = r_m_valid;
    assign blk_cnt       = r_blk_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gost_block_packer.sv
//==============================================================================
// Module   : tb_gost_block_packer
// Purpose  : Self-checking bench for gost_block_packer (directed + random).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gost_block_packer;

    localparam int         MSB  = 1;
    localparam logic [7:0] PADB = 8'h00;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } blk_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic [31:0] blk_cnt;

    int          n_cmp  = 0;
    int          n_fail = 0;
    blk_t        q[$];
    logic [7:0]  cur[$];
    logic [31:0] exp_cnt = 32'h0;
    bit          rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    blk_t        prev_out;

    gost_block_packer #(.MSB_FIRST(MSB), .PAD_BYTE(PADB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .blk_cnt       (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte k of a block sits k byte positions from the "first" end.
    function automatic logic [63:0] place(input logic [63:0] blk, input int k, input logic [7:0] v);
        if (MSB != 0) return blk | ({56'h0, v} << (56 - 8*k));
        else          return blk | ({56'h0, v} << (8*k));
    endfunction

    function automatic logic [7:0] keep_bit(input int k);
        return (MSB != 0) ? (8'h80 >> k) : (8'h01 << k);
    endfunction

    task automatic model_complete(input logic last);
        blk_t b;
        int   n;
        n   = cur.size();
        b.d = 64'h0;
        b.k = 8'h0;
        for (int k = 0; k < n; k++) begin
            b.d = place(b.d, k, cur[k]);
            b.k = b.k | keep_bit(k);
        end
`ifdef GOST_PAD_EN
        if (last && n < 8) begin
            b.d = place(b.d, n, 8'h80);
            b.k = 8'hFF;
            b.l = 1'b1;
            q.push_back(b);
        end else begin
            b.l = 1'b0;
            q.push_back(b);
            if (last) begin
                b.d = place(64'h0, 0, 8'h80);
                b.k = 8'hFF;
                b.l = 1'b1;
                q.push_back(b);
            end
        end
`else
        for (int k = n; k < 8; k++) b.d = place(b.d, k, PADB);
        b.l = last;
        q.push_back(b);
`endif
        cur.delete();
    endtask

    // Monitor / scoreboard, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur.delete();
            q.delete();
            exp_cnt    = 32'h0;
            prev_stall = 1'b0;
        end else begin
            blk_t e;
            chk("blk_cnt", 64'(blk_cnt), 64'(exp_cnt));
            if (prev_stall) begin
                chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
                chk("hold_data", m_axis_tdata, prev_out.d);
                chk("hold_keep", 64'(m_axis_tkeep), 64'(prev_out.k));
                chk("hold_last", 64'(m_axis_tlast), 64'(prev_out.l));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chk("block_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_data", m_axis_tdata, e.d);
                    chk("sb_keep", 64'(m_axis_tkeep), 64'(e.k));
                    chk("sb_last", 64'(m_axis_tlast), 64'(e.l));
                end
                exp_cnt = exp_cnt + 32'd1;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                cur.push_back(s_axis_tdata);
                if (cur.size() == 8 || s_axis_tlast) model_complete(s_axis_tlast);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out.d = m_axis_tdata;
            prev_out.k = m_axis_tkeep;
            prev_out.l = m_axis_tlast;
        end
    end

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int   t;
        logic acc;
        t             = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        do begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        chk("s_accept", 64'(acc), 64'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t             = 0;
        rand_ready    = 1'b0;
        m_axis_tready = 1'b1;
        while ((q.size() != 0 || m_axis_tvalid) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_data", m_axis_tdata, 64'h0);
        chk("rst_m_keep", 64'(m_axis_tkeep), 64'h0);
        chk("rst_m_last", 64'(m_axis_tlast), 64'h0);
        chk("rst_blk_cnt", 64'(blk_cnt), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Downstream stalled while two blocks arrive.
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0);
        @(negedge clk);
        chk("stall_s_ready", 64'(s_axis_tready), 64'd0);
        chk("stall_m_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_m_data", m_axis_tdata, 64'h0102030405060708);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        drain();
        @(negedge clk);
        chk("stall_blk_cnt", 64'(blk_cnt), 64'd2);
        @(posedge clk);
        #1;

        // Back-to-back full block, latency one cycle.
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        @(negedge clk);
        chk("full_valid", 64'(m_axis_tvalid), 64'd1);
        chk("full_data", m_axis_tdata, 64'h0102030405060708);
        chk("full_keep", 64'(m_axis_tkeep), 64'hFF);
        chk("full_last", 64'(m_axis_tlast), 64'd0);
        drain();

        // Short final block.
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        @(negedge clk);
        chk("short_valid", 64'(m_axis_tvalid), 64'd1);
`ifdef GOST_PAD_EN
        chk("short_data", m_axis_tdata, 64'hAABBCC8000000000);
        chk("short_keep", 64'(m_axis_tkeep), 64'hFF);
`else
        chk("short_data", m_axis_tdata, 64'hAABBCC0000000000);
        chk("short_keep", 64'(m_axis_tkeep), 64'hE0);
`endif
        chk("short_last", 64'(m_axis_tlast), 64'd1);
        drain();

        // Message ending exactly on a full block.
        for (int i = 0; i < 8; i++) send_byte(8'(8'h21 + i), i == 7);
        @(negedge clk);
        chk("end8_data", m_axis_tdata, 64'h2122232425262728);
`ifdef GOST_PAD_EN
        chk("end8_last", 64'(m_axis_tlast), 64'd0);
`else
        chk("end8_last", 64'(m_axis_tlast), 64'd1);
`endif
        drain();

        // Reset mid-block discards the partial block.
        for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_s_ready", 64'(s_axis_tready), 64'd0);
        chk("midrst_m_valid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i), 1'b0);
        @(negedge clk);
        chk("postrst_data", m_axis_tdata, 64'h1112131415161718);
        chk("postrst_cnt0", 64'(blk_cnt), 64'd0);
        drain();
        @(negedge clk);
        chk("postrst_cnt1", 64'(blk_cnt), 64'd1);

        // Counter wrap via backdoor.
        @(posedge clk);
        #2;
        force dut.r_blk_cnt = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_blk_cnt;
        @(negedge clk);
        chk("wrap_pre", 64'(blk_cnt), 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
        drain();
        @(negedge clk);
        chk("wrap_post", 64'(blk_cnt), 64'd0);
        @(posedge clk);
        #1;

        // Random messages with random backpressure.
        rand_ready = 1'b1;
        for (int m = 0; m < 30; m++) begin
            int len;
            len = int'($urandom_range(1, 20));
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send_byte(8'($urandom), b == len - 1);
            end
        end
        drain();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
